// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: format codes, RV base opcodes
// and the opcode-to-format classifier.
package imm_gen_stage_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct3[2] separates the immediate CSR forms (uimm in rs1 field) from the rest
  function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
    fmt_e f;
    f = FMT_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                         f = FMT_U;
      OPC_JAL:                                    f = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: f = FMT_I;
      OPC_BRANCH:                                 f = FMT_B;
      OPC_STORE:                                  f = FMT_S;
      OPC_SYSTEM:                                 f = funct3[2] ? FMT_Z : FMT_I;
      default:                                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// The immediate is assembled at 32 bits and then sign-extended to XLEN.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic signed [31:0] imm32;

  always_comb begin
    illegal_o = (instr_i[1:0] != 2'b11);
    fmt_o     = illegal_o ? FMT_NONE : fmt_of(instr_i[6:0], instr_i[14:12]);
    imm32     = '0;
    case (fmt_o)
      FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm32 = {instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      FMT_Z: imm32 = {27'b0, instr_i[19:15]};
      default: imm32 = '0;
    endcase
    imm_o = XLEN'(imm32);
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipeline stage: decodes the immediate on entry, registers it with the pc and
// produces pc+imm. SKID=1 adds a second entry so in_ready is a pure register.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  fmt_e            out_fmt_q, out_fmt_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            out_ill_q, out_ill_d;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  fmt_e            skid_fmt_q, skid_fmt_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            skid_ill_q, skid_ill_d;

  logic accept;
  logic out_free;

  always_comb begin
    if (SKID != 0) begin
      in_ready = rst_n & ~skid_valid_q;
    end else begin
      in_ready = rst_n & (~out_valid_q | out_ready);
    end
    accept   = in_valid & in_ready;
    out_free = ~out_valid_q | out_ready;

    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_pc_d     = out_pc_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_pc_d    = skid_pc_q;
    skid_ill_d   = skid_ill_q;

    // flush wins over any accept or skid promotion in the same cycle
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_pc_d     = skid_pc_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_pc_d    = in_pc;
        out_ill_d   = dec_illegal;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && SKID != 0) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_pc_d    = in_pc;
      skid_ill_d   = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_pc_q     <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_pc_q    <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_pc_q     <= out_pc_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_pc_q    <= skid_pc_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_pc      = out_pc_q;
  assign out_illegal = out_ill_q;
  assign out_target  = out_pc_q + out_imm_q;

endmodule
